// File: rtl/exponential_param_if.sv
// Handshake bundle for the exponential engine.
//   master : requester side; drives start/x/neg, observes busy/done/result
//   slave  : engine side; samples start/x/neg, drives busy/done/intpart/fracpart
interface exponential_param_if #(
   parameter int WIDTH = 16,
   parameter int INT_W = 2
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic             neg;
   logic             busy;
   logic             done;
   logic [INT_W-1:0] intpart;
   logic [WIDTH-1:0] fracpart;

   modport master (
      output start, x, neg,
      input  busy, done, intpart, fracpart
   );

   modport slave (
      input  start, x, neg,
      output busy, done, intpart, fracpart
   );
endinterface

// File: rtl/exponential_param.sv
// Iterative e^x / e^-x engine for unsigned fractional x in [0,1).
// Truncated Taylor series evaluated by Horner's rule, one multiply per clock:
//    acc = 1 +/- (x * acc) / k   for k = TERMS-1 down to 1
// Ports:
//    clk  - clock, all state on rising edge
//    rst  - asynchronous active-high reset
//    bus  - slave side of exponential_param_if (start/x/neg in,
//           busy/done/intpart/fracpart out)
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; done pulse visible here for one cycle
// S_MUL_X | p = (xr * acc) >> WIDTH
// S_MUL_R | q = p / k via reciprocal ROM, acc = 1 +/- q, step k
module exponential_param #(
   parameter int WIDTH = 16,
   parameter int TERMS = 8,
   parameter int INT_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   exponential_param_if.slave bus
);

   localparam int AW = INT_W + WIDTH;
   localparam int PW = AW + WIDTH;
   localparam logic [AW-1:0] ONE = AW'(1) << WIDTH;

   // recip[k] = floor(2^WIDTH / k), packed WIDTH bits per entry; k=0,1 unused
   function automatic logic [16*WIDTH-1:0] gen_recip();
      logic [16*WIDTH-1:0] rom;
      rom = '0;
      for (int i = 2; i < 16; i++) begin
         rom[i*WIDTH +: WIDTH] = WIDTH'((64'd1 << WIDTH) / 64'(i));
      end
      return rom;
   endfunction

   localparam logic [16*WIDTH-1:0] RECIP_ROM = gen_recip();

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MUL_X = 2'd1,
      S_MUL_R = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] xr_q, xr_d;
   logic             nr_q, nr_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [AW-1:0]    p_q, p_d;
   logic [3:0]       k_q, k_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [INT_W-1:0] intpart_q, intpart_d;
   logic [WIDTH-1:0] fracpart_q, fracpart_d;

   logic [WIDTH-1:0] recip;
   logic [AW-1:0]    p_next;
   logic [AW-1:0]    q;
   logic [AW:0]      sum_pos;
   logic [AW-1:0]    acc_new;

   // ---------------------------------------------------------------
   // datapath arithmetic
   // ---------------------------------------------------------------
   always_comb begin
      recip   = RECIP_ROM[32'(k_q)*WIDTH +: WIDTH];
      p_next  = AW'((PW'(xr_q) * PW'(acc_q)) >> WIDTH);
      // k=1 divides by one, so the ROM multiply is skipped
      q       = (k_q == 4'd1) ? p_q : AW'((PW'(p_q) * PW'(recip)) >> WIDTH);
      sum_pos = {1'b0, ONE} + {1'b0, q};
      if (nr_q) begin
         acc_new = (q > ONE) ? '0 : (ONE - q);
      end else begin
         acc_new = sum_pos[AW] ? '1 : sum_pos[AW-1:0];
      end
   end

   // ---------------------------------------------------------------
   // state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_MUL_X;
         S_MUL_X: state_d = S_MUL_R;
         S_MUL_R: state_d = (k_q == 4'd1) ? S_IDLE : S_MUL_X;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // output / datapath next values
   // ---------------------------------------------------------------
   always_comb begin
      xr_d       = xr_q;
      nr_d       = nr_q;
      acc_d      = acc_q;
      p_d        = p_q;
      k_d        = k_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      intpart_d  = intpart_q;
      fracpart_d = fracpart_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               xr_d   = bus.x;
               nr_d   = bus.neg;
               acc_d  = ONE;
               k_d    = 4'(TERMS - 1);
               busy_d = 1'b1;
            end
         end
         S_MUL_X: begin
            p_d = p_next;
         end
         S_MUL_R: begin
            acc_d = acc_new;
            if (k_q == 4'd1) begin
               intpart_d  = acc_new[AW-1:WIDTH];
               fracpart_d = acc_new[WIDTH-1:0];
               done_d     = 1'b1;
               busy_d     = 1'b0;
            end else begin
               k_d = k_q - 4'd1;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xr_q       <= '0;
         nr_q       <= 1'b0;
         acc_q      <= '0;
         p_q        <= '0;
         k_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         intpart_q  <= '0;
         fracpart_q <= '0;
      end else begin
         xr_q       <= xr_d;
         nr_q       <= nr_d;
         acc_q      <= acc_d;
         p_q        <= p_d;
         k_q        <= k_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         intpart_q  <= intpart_d;
         fracpart_q <= fracpart_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.intpart  = intpart_q;
   assign bus.fracpart = fracpart_q;

endmodule

// File: tb/tb_exponential_param.sv
module tb_exponential_param;

   localparam int WA = 16, TA = 8;
   localparam int WB = 12, TB = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   exponential_param_if #(.WIDTH(WA), .INT_W(2)) bus_a ();
   exponential_param_if #(.WIDTH(WB), .INT_W(2)) bus_b ();

   exponential_param #(.WIDTH(WA), .TERMS(TA), .INT_W(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   exponential_param #(.WIDTH(WB), .TERMS(TB), .INT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   typedef struct {
      int expv;
      int tol;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string nm, input int act, input int expv, input int tol);
      int diff;
      vectors++;
      diff = act - expv;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", nm, act, expv, tol);
      end
   endtask

   // Ideal truncated Taylor partial sum, sum_{k<terms} (+/-x)^k / k!, scaled by 2^w
   function automatic int model(input int xv, input bit ng, input int w, input int terms);
      real xf, s, t;
      xf = real'(xv) / (2.0 ** w);
      if (ng) xf = -xf;
      s = 0.0;
      t = 1.0;
      for (int k = 0; k < terms; k++) begin
         s = s + t;
         t = t * xf / real'(k + 1);
      end
      return $rtoi(s * (2.0 ** w));
   endfunction

   task automatic push(input bit sel, input int expv, input int tol);
      exp_t e;
      e.expv = expv;
      e.tol  = tol;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
   endtask

   task automatic drive(input bit sel, input int xv, input bit ng, input bit st);
      if (sel) begin
         bus_b.x = WB'(xv); bus_b.neg = ng; bus_b.start = st;
      end else begin
         bus_a.x = WA'(xv); bus_a.neg = ng; bus_a.start = st;
      end
   endtask

   task automatic set_start(input bit sel, input bit st);
      if (sel) bus_b.start = st;
      else     bus_a.start = st;
   endtask

   function automatic bit cur_done(input bit sel);
      return sel ? bus_b.done : bus_a.done;
   endfunction

   function automatic bit cur_busy(input bit sel);
      return sel ? bus_b.busy : bus_a.busy;
   endfunction

   function automatic int cur_result(input bit sel);
      return sel ? int'({bus_b.intpart, bus_b.fracpart}) : int'({bus_a.intpart, bus_a.fracpart});
   endfunction

   // ---------------- monitors: pop and compare on every done ----------------
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst && bus_a.done) begin
         if (q_a.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done_a: got result 0x%0h, expected no done", cur_result(0));
         end else begin
            e = q_a.pop_front();
            check("result_a", cur_result(0), e.expv, e.tol);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst && bus_b.done) begin
         if (q_b.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done_b: got result 0x%0h, expected no done", cur_result(1));
         end else begin
            e = q_b.pop_front();
            check("result_b", cur_result(1), e.expv, e.tol);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done(input bit sel, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!cur_done(sel) && n < 60);
   endtask

   // One operation; optionally pulses start (with x=px) while busy to show it is ignored
   task automatic run_op(input bit sel, input int xv, input bit ng, input int expv,
                         input int tol, input int pulse_at, input int px);
      int  n;
      bit  bz_ok;
      int  lat;
      lat = sel ? 2*(TB-1) : 2*(TA-1);
      @(negedge clk);
      drive(sel, xv, ng, 1'b1);
      push(sel, expv, tol);
      @(posedge clk);
      n = 0;
      bz_ok = 1'b1;
      do begin
         @(negedge clk);
         if (pulse_at != 0 && n == pulse_at) drive(sel, px, ~ng, 1'b1);
         else set_start(sel, 1'b0);
         @(posedge clk); #1;
         n++;
         if (!cur_done(sel) && !cur_busy(sel)) bz_ok = 1'b0;
      end while (!cur_done(sel) && n < 60);
      check("latency", n, lat, 0);
      check("busy_during_op", int'(bz_ok), 1, 0);
      check("busy_at_done", int'(cur_busy(sel)), 0, 0);
      @(negedge clk);
      set_start(sel, 1'b0);
      @(posedge clk); #1;
      check("done_one_cycle", int'(cur_done(sel)), 0, 0);
   endtask

   task automatic reset_mid_op(input bit sel);
      @(negedge clk);
      drive(sel, 'h1234, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(sel, 1'b0);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_busy", int'(cur_busy(sel)), 0, 0);
      check("rst_done", int'(cur_done(sel)), 0, 0);
      check("rst_result", cur_result(sel), 0, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rst_idle_busy", int'(cur_busy(sel)), 0, 0);
   endtask

   initial begin
      int n;
      int xv;
      bit ng;

      drive(0, 0, 0, 0);
      drive(1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("reset_busy_a", int'(bus_a.busy), 0, 0);
      check("reset_done_a", int'(bus_a.done), 0, 0);
      check("reset_result_a", cur_result(0), 0, 0);
      check("reset_busy_b", int'(bus_b.busy), 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // directed values, WIDTH=16 TERMS=8
      run_op(0, 'h8000, 0, 'h1A612, 8, 0, 0);
      run_op(0, 'hCCCC, 0, 'h239BB, 8, 0, 0);
      run_op(0, 'h3333, 0, 'h138AD, 8, 0, 0);
      run_op(0, 'h0000, 0, 'h10000, 0, 0, 0);
      run_op(0, 'h0000, 1, 'h10000, 0, 0, 0);
      run_op(0, 'h8000, 1, 'h09B46, 8, 0, 0);
      run_op(0, 'hFFFF, 1, 'h05E2D, 8, 0, 0);

      // start pulsed three cycles into an operation is ignored
      run_op(0, 'h8000, 0, 'h1A612, 8, 3, 'h3333);
      repeat (20) @(posedge clk);

      // start held high: back-to-back results 15 cycles apart
      @(negedge clk);
      drive(0, 'h8000, 0, 1'b1);
      push(0, 'h1A612, 8);
      @(posedge clk);
      @(negedge clk);
      drive(0, 'hCCCC, 0, 1'b1);
      push(0, 'h239BB, 8);
      wait_done(0, n);
      check("b2b_first_latency", n, 14, 0);
      @(posedge clk);
      @(negedge clk);
      set_start(0, 1'b0);
      wait_done(0, n);
      check("b2b_period", n + 1, 15, 0);
      repeat (20) @(posedge clk);

      // asynchronous reset mid-operation, then a clean operation
      reset_mid_op(0);
      run_op(0, 'h8000, 0, 'h1A612, 8, 0, 0);

      // randomized, with stray start pulses while busy
      for (int i = 0; i < 25; i++) begin
         xv = int'($urandom_range(0, 65535));
         ng = 1'($urandom_range(0, 1));
         run_op(0, xv, ng, model(xv, ng, WA, TA), TA,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 65535)));
      end

      // WIDTH=12, TERMS=6 instance
      run_op(1, 'h800, 0, 'h1A61, 6, 0, 0);
      reset_mid_op(1);
      run_op(1, 'h800, 0, 'h1A61, 6, 0, 0);
      run_op(1, 'h000, 1, 'h1000, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         xv = int'($urandom_range(0, 4095));
         ng = 1'($urandom_range(0, 1));
         run_op(1, xv, ng, model(xv, ng, WB, TB), TB,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 4095)));
      end

      repeat (5) @(negedge clk);
      check("scoreboard_a_drained", q_a.size(), 0, 0);
      check("scoreboard_b_drained", q_b.size(), 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/exponential_param.md
Name: exponential_param

Overview:
- Parametrised, iterative e^x / e^-x engine for unsigned fractional inputs x in [0,1).
- Evaluates a truncated Taylor series by Horner's rule, one multiply per clock.
- Generalises the fixed 16-bit exponential accelerator with configurable fraction width, term count and integer width, a sign mode, and a busy flag.
- Intended for use behind bus/handshake wrappers in the accelerator lab designs.

Parameters:
WIDTH, 16, fraction bits of x and fracpart (8..24)
TERMS, 8, Taylor terms evaluated (1/0! .. 1/(TERMS-1)!); legal 2..16
INT_W, 2, integer bits of result; must be >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
x  input  WIDTH  unsigned fraction, value x/2^WIDTH, captured when start accepted
neg  input  1  0: compute e^x; 1: compute e^-x; captured with x
busy  output  1  high while an evaluation is in progress
done  output  1  one-cycle pulse when intpart/fracpart are updated
intpart  output  INT_W  integer part of result
fracpart  output  WIDTH  fractional part of result

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE; busy, done, intpart and fracpart all 0; captured x, neg, acc and k cleared. Operation resumes on the first start after rst deasserts.
- Internal registers:
  - xr (WIDTH bits), nr (1 bit)
  - acc: unsigned, INT_W+WIDTH bits, fixed point with WIDTH fraction bits
  - p: WIDTH+INT_W bits
  - k: 4-bit term index
- Reciprocal ROM: recip[k] = floor(2^WIDTH / k) for k = 2..15, generated from WIDTH. For k=1 the reciprocal multiply is bypassed (q = p).
- FSM states: IDLE, MUL_X, MUL_R.
- IDLE:
  - done is driven by its register; it is cleared on every edge except the final MUL_R edge.
  - If start=1: xr<=x, nr<=neg, acc<=1.0, k<=TERMS-1, busy<=1, go to MUL_X.
- MUL_X: p <= (xr*acc) >> WIDTH (truncate); go to MUL_R.
- MUL_R:
  - q = (k==1) ? p : (p*recip[k]) >> WIDTH (truncate).
  - acc <= nr ? sat0(1.0 - q) : satmax(1.0 + q).
    - sat0 clamps negative results to 0.
    - satmax clamps to all-ones on overflow of INT_W+WIDTH bits.
  - If k==1: load {intpart,fracpart} <= new acc, done<=1, busy<=0, go to IDLE.
  - Else: k<=k-1, go to MUL_X.
- Latency: done rises 2*(TERMS-1) clock edges after the edge that accepted start (14 for TERMS=8). Throughput: one result per 2*(TERMS-1)+1 cycles when start is held high.
- done is high for exactly one cycle. intpart/fracpart hold their value until the next done or reset.
- start while busy=1 is ignored: xr/neg are not re-captured and the running result is unaffected.
- start in the cycle done=1 (state IDLE) is accepted.
- x or neg changes after acceptance have no effect.
- x=0 gives exactly 1.0 (intpart=1, fracpart=0) in both modes.
- Accuracy: truncation error at most TERMS LSB versus the ideal value. No saturation occurs for legal parameters; saturation logic exists only for safety.

Test Plan:
- Reset: assert rst 3 ns mid-cycle → busy=0, done=0, intpart=0, fracpart=0 immediately, without waiting for a clock.
- Defaults, x=16'h8000, neg=0, start for 1 cycle → done exactly 14 edges later, one cycle wide; intpart=1, fracpart=16'hA612 ±8; busy high for those 14 cycles.
- x=16'hCCCC → intpart=2, fracpart=16'h39BB ±8. x=16'h3333 → intpart=1, fracpart=16'h38AD ±8. x=0 with neg=0 and neg=1 → exactly 1, 16'h0000.
- neg=1, x=16'h8000 → intpart=0, fracpart=16'h9B46 ±8. neg=1, x=16'hFFFF → intpart=0, fracpart=16'h5E2D ±8.
- Pulse start with x=16'h3333 three cycles after accepting x=16'h8000 → result 1/16'hA612 ±8, no second done. Then hold start high → back-to-back done pulses 15 cycles apart.
- rst pulsed at cycle 5 of an operation → outputs 0, busy 0, no done. Next start with x=16'h8000 → correct result after 14 edges. Repeat with WIDTH=12, TERMS=6: x=12'h800 → intpart=1, fracpart=12'hA61 ±6, done after 10 edges.
